// File: rtl/probe_trace_recorder_if.sv
// Record stream from a probe trace recorder to its consumer.
// The master presents the FIFO head; the slave accepts it with rec_ready.
interface probe_trace_recorder_if #(
    parameter int REC_W = 97
);
    logic             rec_valid;
    logic             rec_ready;
    logic [REC_W-1:0] rec_data;

    modport master (
        output rec_valid,
        output rec_data,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_data,
        output rec_ready
    );
endinterface

// File: rtl/probe_trace_recorder.sv
// Per-cell probe trace capture: packs sequencer and register-file
// activity into timestamped records and drains them through a FIFO.
module probe_trace_recorder #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 6,
    parameter int PC_W    = 6,
    parameter int INSTR_W = 27,
    parameter int TS_W    = 16,
    parameter int DEPTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [PC_W-1:0]          pc,
    input  logic [INSTR_W-1:0]       instr,
    input  logic                     addren_in0,
    input  logic [ADDR_W-1:0]        addr_in0,
    input  logic [DATA_W-1:0]        data_in0,
    input  logic                     addren_out0,
    input  logic [ADDR_W-1:0]        addr_out0,
    input  logic [DATA_W-1:0]        data_out0,
    probe_trace_recorder_if.master   rec_if,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              drop_count,
    output logic                     overflow
);
    localparam int REC_W = TS_W + 4 + PC_W + INSTR_W + 2 * (ADDR_W + DATA_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [PC_W-1:0]  ph_q, ph_d;
    logic             hv_q, hv_d;
    logic             lost_q, lost_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      drop_q, drop_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    logic [REC_W-1:0] mem [DEPTH];

    logic             ev_pc, ev_wr, ev_rd;
    logic             form, pop, push, drop, wr_en;
    logic             valid;
    logic [REC_W-1:0] rec_w;

    assign valid = (level_q != '0);

    always_comb begin
        ev_pc = enable & (~hv_q | (pc != ph_q));
        ev_wr = enable & addren_in0;
        ev_rd = enable & addren_out0;
        form  = ev_pc | ev_wr | ev_rd;
        pop   = valid & rec_if.rec_ready;
        push  = form & ((level_q != LVL_W'(DEPTH)) | pop);
        drop  = form & ~push;
        wr_en = push & ~clear;

        // Fields of unflagged events are masked to zero
        rec_w = {ts_q, lost_q, ev_pc, ev_wr, ev_rd,
                 pc       & {PC_W{ev_pc}},
                 instr    & {INSTR_W{ev_pc}},
                 addr_in0 & {ADDR_W{ev_wr}},
                 data_in0 & {DATA_W{ev_wr}},
                 addr_out0 & {ADDR_W{ev_rd}},
                 data_out0 & {DATA_W{ev_rd}}};
    end

    always_comb begin
        ts_d    = ts_q;
        ph_d    = ph_q;
        hv_d    = hv_q;
        lost_d  = lost_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;

        if (enable) begin
            ts_d = ts_q + TS_W'(1);
            ph_d = pc;
            hv_d = 1'b1;
        end
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
            lost_d = 1'b0;
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
        if (drop) begin
            lost_d = 1'b1;
            ovf_d  = 1'b1;
            if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end

        // Flush wins over any push or pop in the same cycle
        if (clear) begin
            ts_d    = '0;
            ph_d    = '0;
            hv_d    = 1'b0;
            lost_d  = 1'b0;
            ovf_d   = 1'b0;
            drop_d  = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q    <= '0;
            ph_q    <= '0;
            hv_q    <= 1'b0;
            lost_q  <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            ts_q    <= ts_d;
            ph_q    <= ph_d;
            hv_q    <= hv_d;
            lost_q  <= lost_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= rec_w;
        end
    end

    assign rec_if.rec_valid = valid;
    assign rec_if.rec_data  = valid ? mem[rptr_q] : '0;
    assign level            = level_q;
    assign drop_count       = drop_q;
    assign overflow         = ovf_q;
endmodule

// File: tb/tb_probe_trace_recorder.sv
// Directed and randomized bench for probe_trace_recorder against a
// queue-based record model.
module tb_probe_trace_recorder;
    localparam int RW    = 97;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [5:0]  pc = '0;
    logic [26:0] instr = '0;
    logic        ai = 1'b0;
    logic [5:0]  aa = '0;
    logic [15:0] ad = '0;
    logic        ao = 1'b0;
    logic [5:0]  ba = '0;
    logic [15:0] bd = '0;
    wire  [4:0]  level;
    wire  [15:0] drop_count;
    wire         overflow;

    probe_trace_recorder_if #(.REC_W(RW)) rif ();

    probe_trace_recorder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clear       (clear),
        .pc          (pc),
        .instr       (instr),
        .addren_in0  (ai),
        .addr_in0    (aa),
        .data_in0    (ad),
        .addren_out0 (ao),
        .addr_out0   (ba),
        .data_out0   (bd),
        .rec_if      (rif),
        .level       (level),
        .drop_count  (drop_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    logic [RW-1:0] q[$];
    int            m_ts;
    logic [5:0]    m_ph;
    bit            m_hv, m_lost, m_ovf;
    int            m_drop;
    int            n_chk = 0;
    int            n_err = 0;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ts = 0; m_ph = '0; m_hv = 0;
        m_lost = 0; m_ovf = 0; m_drop = 0;
    endtask

    function automatic logic [RW-1:0] mk(int ts, bit l, bit p, bit w, bit r);
        return {16'(ts), l, p, w, r,
                p ? pc : 6'd0, p ? instr : 27'd0,
                w ? aa : 6'd0, w ? ad : 16'd0,
                r ? ba : 6'd0, r ? bd : 16'd0};
    endfunction

    // One clock of the spec's rules, evaluated from pre-edge inputs
    task automatic model_tick();
        bit p, w, r, form, pop, acc;
        int sz;
        if (clear) begin
            model_reset();
            return;
        end
        p = enable && (!m_hv || pc != m_ph);
        w = enable && ai;
        r = enable && ao;
        form = p || w || r;
        sz = q.size();
        pop = sz > 0 && rif.rec_ready;
        acc = form && (sz < DEPTH || pop);
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back(mk(m_ts, m_lost, p, w, r));
            m_lost = 0;
        end else if (form) begin
            if (m_drop < 65535) m_drop++;
            m_ovf = 1;
            m_lost = 1;
        end
        if (enable) begin
            m_ph = pc;
            m_hv = 1;
            m_ts = (m_ts + 1) % 65536;
        end
    endtask

    task automatic cmp_all();
        logic [RW-1:0] hd;
        hd = '0;
        if (q.size() != 0) hd = q[0];
        chk("rec_valid", rif.rec_valid, q.size() != 0);
        chk("rec_data", rif.rec_data, hd);
        chk("level", level, q.size());
        chk("drop_count", drop_count, m_drop);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic step(bit do_chk);
        model_tick();
        @(posedge clk);
        #1;
        if (do_chk) cmp_all();
    endtask

    task automatic drive(bit en, logic [5:0] p, bit w, bit r);
        enable = en; pc = p; ai = w; ao = r;
        instr = 27'($urandom);
        aa = 6'($urandom); ad = 16'($urandom);
        ba = 6'($urandom); bd = 16'($urandom);
    endtask

    task automatic drain();
        int g;
        rif.rec_ready = 1'b1;
        drive(0, pc, 0, 0);
        g = 0;
        while (rif.rec_valid && g < 40) begin
            step(1);
            g++;
        end
        chk("drained", rif.rec_valid, 0);
    endtask

    initial begin
        int k, nl, pos;
        rif.rec_ready = 1'b0;
        model_reset();
        #12;
        cmp_all();
        rst_n = 1'b1;

        // Constant pc: only the first enabled cycle is an event
        for (int i = 0; i < 4; i++) begin
            drive(1, 6'd5, 0, 0);
            step(1);
        end
        chk("t1_level", level, 1);
        chk("t1_ts", rif.rec_data[96:81], 0);
        chk("t1_flags", rif.rec_data[80:77], 4'b0100);
        chk("t1_pc", rif.rec_data[76:71], 5);
        drain();

        // All three events in one record
        drive(1, 6'd6, 1, 1);
        aa = 6'd3; ad = 16'hABCD; ba = 6'd7;
        step(1);
        chk("t2_flags", rif.rec_data[80:77], 4'b0111);
        chk("t2_pc", rif.rec_data[76:71], 6);
        chk("t2_wr", rif.rec_data[43:22], {6'd3, 16'hABCD});
        chk("t2_rd_addr", rif.rec_data[21:16], 7);
        drain();

        // Idle to ts=9, then a lone write event
        for (int i = 0; i < 4; i++) begin
            drive(1, 6'd6, 0, 0);
            step(1);
        end
        drive(1, 6'd6, 1, 0);
        step(1);
        chk("t3_ts", rif.rec_data[96:81], 9);
        chk("t3_flags", rif.rec_data[80:77], 4'b0010);
        chk("t3_rd_zero", rif.rec_data[21:0], 0);
        drain();

        // Overfill, then push against a simultaneous pop
        rif.rec_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1, 6'd6, 1, 0);
            step(1);
        end
        chk("t4_level", level, 16);
        chk("t4_drops", drop_count, 4);
        chk("t4_ovf", overflow, 1);
        rif.rec_ready = 1'b1;
        drive(1, 6'd6, 1, 0);
        step(1);
        chk("t4_full_pop_level", level, 16);
        chk("t4_full_pop_drops", drop_count, 4);
        drive(1, 6'd6, 1, 0);
        step(1);
        drive(0, 6'd6, 0, 0);
        k = 0; nl = 0; pos = -1;
        while (rif.rec_valid && k < 40) begin
            if (rif.rec_data[80]) begin
                nl++;
                pos = k;
            end
            k++;
            step(1);
        end
        chk("t4_lost_count", nl, 1);
        chk("t4_lost_pos", pos, 14);
        chk("t4_drain_len", k, 16);

        // Async reset in the middle of a burst
        rif.rec_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1, 6'd6, 1, 0);
            step(1);
        end
        chk("t5_level", level, 7);
        rst_n = 1'b0;
        #2;
        model_reset();
        cmp_all();
        #2;
        rst_n = 1'b1;
        drive(1, 6'd6, 0, 0);
        step(1);
        chk("t5_evpc", rif.rec_data[79], 1);
        chk("t5_ts", rif.rec_data[96:81], 0);

        // Timestamp wrap
        rif.rec_ready = 1'b1;
        drive(1, 6'd6, 0, 0);
        for (int i = 0; i < 65535; i++) step(0);
        drive(1, 6'd9, 0, 0);
        step(1);
        chk("wrap_ts", rif.rec_data[96:81], 0);
        chk("wrap_flags", rif.rec_data[80:77], 4'b0100);
        drain();

        // Clear wins over a concurrent event and resets history
        rif.rec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 6'd9, 1, 1);
            step(1);
        end
        drive(1, 6'd9, 1, 0);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        drive(1, 6'd9, 0, 0);
        step(1);
        chk("clr_ts", rif.rec_data[96:81], 0);
        chk("clr_evpc", rif.rec_data[79], 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, 6'($urandom % 4),
                  ($urandom % 3) == 0, ($urandom % 3) == 0);
            rif.rec_ready = ($urandom % 3) == 0;
            clear = ($urandom % 64) == 0;
            step(1);
        end
        clear = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
